pipelined_control_unit: RTL and testbench
=========================================

PIPELINED_CONTROL_UNIT -- requirements
Module: pipelined_control_unit

Interface
REQ-001 Parameter REG_W, default 5, register-specifier width.
REQ-002 Parameter IMM_OPS_EN, default 1; 1 = decode ADDI/ANDI/SLTI/ORI/XORI, 0 = treat them as illegal.
REQ-003 Parameter ALUOP_W, default 2, ALU-op field width; must be at least 2.
REQ-004 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port id_opcode, input, 6, opcode of the instruction in ID.
REQ-007 Port id_rs / id_rt / id_rd, input, REG_W each, register fields of the instruction in ID.
REQ-008 Port flush, input, 1, branch resolved taken; the ID instruction is squashed.
REQ-009 Port de_branch / de_bne, output, 1 each, combinational ID branch controls for the current id_opcode.
REQ-010 Port stall, output, 1, combinational load-use hazard; PC and IF/ID must hold.
REQ-011 Port ex_regdst, ex_alusrc (1 each) and ex_aluop (ALUOP_W), output, registered ID/EX controls.
REQ-012 Port mem_read / mem_write, output, 1 each, registered EX/MEM controls.
REQ-013 Port wb_regwrite, wb_memtoreg (1 each) and wb_dst (REG_W), output, registered MEM/WB controls and destination.
REQ-014 Port ex_illegal, output, 1, registered; high while an undecodable opcode occupies EX.

Function
REQ-015 Decode table (RegDst, ALUSrc, ALUOp, MemRead, MemWrite, RegWrite, MemToReg, Branch, BNE):
- LW 100011 -> 0,1,00,1,0,1,1,0,0
- SW 101011 -> 0,1,00,0,1,0,0,0,0
- BEQ 000100 -> 0,0,01,0,0,0,0,1,0
- BNE 000101 -> 0,0,01,0,0,0,0,1,1
- R 000000 -> 1,0,10,0,0,1,0,0,0
- ADDI/ANDI/SLTI/ORI/XORI (001000/001100/001010/001101/001110) -> 0,1,11,0,0,1,0,0,0
REQ-016 Any other opcode decodes to all zeros plus the illegal bit; no decoded bit may ever be X.
REQ-017 ALUOp values are zero-extended to ALUOP_W.
REQ-018 Destination is computed in ID: RegDst ? id_rd : id_rt. It travels with the bundle ID/EX -> EX/MEM -> MEM/WB.
REQ-019 Each edge without hazard advances the pipeline:
- ID/EX <= decoded bundle
- EX/MEM <= mem and wb fields of ID/EX
- MEM/WB <= wb fields of EX/MEM
REQ-020 Latency: opcode in ID at edge N -> ex_* valid after edge N, mem_* after N+1, wb_* after N+2.
REQ-021 The ID/EX stage holds rt (REG_W) for hazard checking.
REQ-022 stall = idex_memread AND idex_rt != 0 AND (idex_rt == id_rs OR (id_uses_rt AND idex_rt == id_rt)).
REQ-023 id_uses_rt is 1 for R-type, BEQ, BNE and SW, and 0 otherwise.
REQ-024 On stall or flush, ID/EX loads a bubble: all controls 0, dst 0, illegal 0. EX/MEM and MEM/WB still advance.
REQ-025 Stall and flush asserted together: bubble inserted once; flush has priority and the pipe does not hold.
REQ-026 A bubble never asserts stall on the following cycle.
REQ-027 de_branch and de_bne follow id_opcode combinationally and are forced to 0 while stall is high.

Reset
REQ-028 On rst_n low, all stage registers clear immediately, regardless of clk, so every registered output is 0.
REQ-029 stall is 0 while in reset.
REQ-030 On rst_n deassertion mid-sequence, the first edge loads the current ID decode; in-flight instructions are not recovered.

Verification
REQ-031 Reset, then R-type (rd=5, rt=3) -> edge 1: ex_regdst=1, ex_aluop=10; edge 3: wb_regwrite=1, wb_dst=5.
REQ-032 LW rt=4, then ADD rs=4 -> stall=1 for one cycle; ID/EX bubble (all 0); the ADD then decodes normally.
REQ-033 LW rt=0, then ADD rs=0 -> stall=0.
REQ-034 LW rt=4, then ADDI rt=4 rs=2 -> stall=0 (rt is not a source for ADDI).
REQ-035 BEQ in ID with flush=1 and stall=1 -> one bubble; next edge advances with stall clear.
REQ-036 Opcode 111111 -> ex_illegal=1, all controls 0. With IMM_OPS_EN=0, ADDI also gives ex_illegal=1. rst_n pulsed low between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Main control decoder plus the ID/EX, EX/MEM and MEM/WB control registers.
// Also detects load-use hazards and inserts bubbles into ID/EX.
module pipelined_control_unit #(
    parameter int REG_W      = 5,
    parameter int IMM_OPS_EN = 1,
    parameter int ALUOP_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         id_opcode,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               flush,
    output logic               de_branch,
    output logic               de_bne,
    output logic               stall,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_W-1:0]   wb_dst,
    output logic               ex_illegal
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;

    localparam logic [ALUOP_W-1:0] AOP_BR = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] AOP_R  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] AOP_I  = ALUOP_W'(3);

    typedef struct packed {
        logic               regdst;
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               memread;
        logic               memwrite;
        logic               regwrite;
        logic               memtoreg;
        logic               illegal;
        logic [REG_W-1:0]   dst;
        logic [REG_W-1:0]   rt;
    } id_ex_t;

    typedef struct packed {
        logic             memread;
        logic             memwrite;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] dst;
    } mem_wb_t;

    id_ex_t  dec;
    id_ex_t  idex;
    ex_mem_t exmem;
    mem_wb_t memwb;

    logic is_r, is_lw, is_sw, is_beq, is_bne, is_imm;
    logic dec_branch, dec_bne, uses_rt;
    logic hazard, bubble;

    assign is_r   = (id_opcode == OP_R);
    assign is_lw  = (id_opcode == OP_LW);
    assign is_sw  = (id_opcode == OP_SW);
    assign is_beq = (id_opcode == OP_BEQ);
    assign is_bne = (id_opcode == OP_BNE);
    assign is_imm = (IMM_OPS_EN != 0) &&
                    (id_opcode == OP_ADDI || id_opcode == OP_ANDI ||
                     id_opcode == OP_SLTI || id_opcode == OP_ORI  ||
                     id_opcode == OP_XORI);

    always_comb begin
        dec        = '0;
        dec_branch = 1'b0;
        dec_bne    = 1'b0;
        uses_rt    = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec.regdst   = 1'b1;
                dec.aluop    = AOP_R;
                dec.regwrite = 1'b1;
                uses_rt      = 1'b1;
            end
            is_lw: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
            end
            is_sw: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                uses_rt      = 1'b1;
            end
            is_beq: begin
                dec.aluop  = AOP_BR;
                dec_branch = 1'b1;
                uses_rt    = 1'b1;
            end
            is_bne: begin
                dec.aluop  = AOP_BR;
                dec_branch = 1'b1;
                dec_bne    = 1'b1;
                uses_rt    = 1'b1;
            end
            is_imm: begin
                dec.alusrc   = 1'b1;
                dec.aluop    = AOP_I;
                dec.regwrite = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.dst = dec.regdst ? id_rd : id_rt;
        dec.rt  = id_rt;
    end

    // A bubble in ID/EX has memread clear, so it can never raise a hazard.
    assign hazard = idex.memread && (idex.rt != '0) &&
                    ((idex.rt == id_rs) || (uses_rt && (idex.rt == id_rt)));

    // Flush wins: the squashed instruction must not be held in IF/ID.
    assign stall     = rst_n && hazard && !flush;
    assign bubble    = hazard || flush;
    assign de_branch = dec_branch && !stall;
    assign de_bne    = dec_bne && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            idex           <= bubble ? '0 : dec;
            exmem.memread  <= idex.memread;
            exmem.memwrite <= idex.memwrite;
            exmem.regwrite <= idex.regwrite;
            exmem.memtoreg <= idex.memtoreg;
            exmem.dst      <= idex.dst;
            memwb.regwrite <= exmem.regwrite;
            memwb.memtoreg <= exmem.memtoreg;
            memwb.dst      <= exmem.dst;
        end
    end

    assign ex_regdst   = idex.regdst;
    assign ex_alusrc   = idex.alusrc;
    assign ex_aluop    = idex.aluop;
    assign ex_illegal  = idex.illegal;
    assign mem_read    = exmem.memread;
    assign mem_write   = exmem.memwrite;
    assign wb_regwrite = memwb.regwrite;
    assign wb_memtoreg = memwb.memtoreg;
    assign wb_dst      = memwb.dst;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: step table plus reset corner cases.
module tb_pipelined_control_unit;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] id_opcode = LW;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       flush = 1'b0;

    logic       de_branch, de_bne, stall;
    logic       ex_regdst, ex_alusrc, ex_illegal;
    logic [1:0] ex_aluop;
    logic       mem_read, mem_write, wb_regwrite, wb_memtoreg;
    logic [4:0] wb_dst;

    logic       n_branch, n_bne, n_stall;
    logic       n_regdst, n_alusrc, n_illegal;
    logic [1:0] n_aluop;
    logic       n_mread, n_mwrite, n_rw, n_mt;
    logic [4:0] n_dst;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .de_branch(de_branch), .de_bne(de_bne), .stall(stall),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .mem_read(mem_read), .mem_write(mem_write),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_dst(wb_dst), .ex_illegal(ex_illegal)
    );

    pipelined_control_unit #(.IMM_OPS_EN(0)) dut_noimm (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .de_branch(n_branch), .de_bne(n_bne), .stall(n_stall),
        .ex_regdst(n_regdst), .ex_alusrc(n_alusrc), .ex_aluop(n_aluop),
        .mem_read(n_mread), .mem_write(n_mwrite),
        .wb_regwrite(n_rw), .wb_memtoreg(n_mt),
        .wb_dst(n_dst), .ex_illegal(n_illegal)
    );

    // ex = {regdst, alusrc, aluop[1:0], illegal}; mem = {read, write}; wb = {regwrite, memtoreg}
    typedef struct {
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       fl, cc, stl, br, bne;
        logic [4:0] ex;
        logic [1:0] mem, wb;
        logic [4:0] dst;
    } vec_t;

    vec_t v[17];

    function automatic vec_t mk(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic fl, logic cc, logic stl,
                                logic br, logic bne, logic [4:0] ex,
                                logic [1:0] mem, logic [1:0] wb, logic [4:0] dst);
        vec_t r;
        r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.fl = fl; r.cc = cc;
        r.stl = stl; r.br = br; r.bne = bne; r.ex = ex; r.mem = mem;
        r.wb = wb; r.dst = dst;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ex_vec();
        return {ex_regdst, ex_alusrc, ex_aluop, ex_illegal};
    endfunction

    task automatic check_all_zero(string tag);
        chk({tag, "_ex"}, 32'(ex_vec()), 32'd0);
        chk({tag, "_mem"}, 32'({mem_read, mem_write}), 32'd0);
        chk({tag, "_wb"}, 32'({wb_regwrite, wb_memtoreg}), 32'd0);
        chk({tag, "_dst"}, 32'(wb_dst), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        v[0]  = mk(R,    1, 3, 5, 0, 1, 0, 0, 0, 5'b10100, 2'b00, 2'b00, 0);
        v[1]  = mk(SW,   6, 7, 9, 0, 1, 0, 0, 0, 5'b01000, 2'b00, 2'b00, 0);
        v[2]  = mk(LW,   1, 4, 0, 0, 1, 0, 0, 0, 5'b01000, 2'b01, 2'b10, 5);
        v[3]  = mk(R,    4, 2, 8, 0, 1, 1, 0, 0, 5'b00000, 2'b10, 2'b00, 7);
        v[4]  = mk(R,    4, 2, 8, 0, 1, 0, 0, 0, 5'b10100, 2'b00, 2'b11, 4);
        v[5]  = mk(LW,   0, 0, 0, 0, 1, 0, 0, 0, 5'b01000, 2'b00, 2'b00, 0);
        v[6]  = mk(R,    0, 0, 6, 0, 1, 0, 0, 0, 5'b10100, 2'b10, 2'b10, 8);
        v[7]  = mk(LW,   3, 4, 0, 0, 1, 0, 0, 0, 5'b01000, 2'b00, 2'b11, 0);
        v[8]  = mk(ADDI, 2, 4, 0, 0, 1, 0, 0, 0, 5'b01110, 2'b10, 2'b10, 6);
        v[9]  = mk(LW,   0, 5, 0, 0, 1, 0, 0, 0, 5'b01000, 2'b00, 2'b11, 4);
        v[10] = mk(BEQ,  1, 5, 0, 1, 0, 0, 0, 0, 5'b00000, 2'b10, 2'b10, 4);
        v[11] = mk(BEQ,  1, 5, 0, 0, 1, 0, 1, 0, 5'b00010, 2'b00, 2'b11, 5);
        v[12] = mk(BNE,  0, 0, 0, 0, 1, 0, 1, 1, 5'b00010, 2'b00, 2'b00, 0);
        v[13] = mk(BAD,  0, 0, 0, 0, 1, 0, 0, 0, 5'b00001, 2'b00, 2'b00, 5);
        v[14] = mk(LW,   0, 9, 0, 0, 1, 0, 0, 0, 5'b01000, 2'b00, 2'b00, 0);
        v[15] = mk(BEQ,  1, 9, 0, 0, 1, 1, 0, 0, 5'b00000, 2'b10, 2'b00, 0);
        v[16] = mk(BEQ,  1, 9, 0, 0, 1, 0, 1, 0, 5'b00010, 2'b00, 2'b11, 9);

        // in reset with a load in ID: everything reads zero
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            id_opcode = v[i].op;
            id_rs = v[i].rs;
            id_rt = v[i].rt;
            id_rd = v[i].rd;
            flush = v[i].fl;
            #2;
            if (v[i].cc) begin
                chk($sformatf("s%0d_stall", i), 32'(stall), 32'(v[i].stl));
                chk($sformatf("s%0d_branch", i), 32'(de_branch), 32'(v[i].br));
                chk($sformatf("s%0d_bne", i), 32'(de_bne), 32'(v[i].bne));
            end
            @(posedge clk);
            #1;
            chk($sformatf("s%0d_ex", i), 32'(ex_vec()), 32'(v[i].ex));
            chk($sformatf("s%0d_mem", i), 32'({mem_read, mem_write}), 32'(v[i].mem));
            chk($sformatf("s%0d_wb", i), 32'({wb_regwrite, wb_memtoreg}), 32'(v[i].wb));
            chk($sformatf("s%0d_dst", i), 32'(wb_dst), 32'(v[i].dst));
            chk($sformatf("s%0d_noimm_ill", i), 32'(n_illegal),
                32'(v[i].ex[0] | (v[i].op == ADDI && !v[i].fl)));
            if (v[i].op == ADDI)
                chk($sformatf("s%0d_noimm_ex", i),
                    32'({n_regdst, n_alusrc, n_aluop}), 32'd0);
        end

        // async reset pulse between edges with a full pipe
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        #1;
        rst_n = 1'b1;
        id_opcode = R;
        id_rs = 1;
        id_rt = 3;
        id_rd = 5;
        @(posedge clk);
        #1;
        chk("post_rst_ex", 32'(ex_vec()), 32'(5'b10100));
        chk("post_rst_mem", 32'({mem_read, mem_write}), 32'd0);
        chk("post_rst_wb", 32'({wb_regwrite, wb_memtoreg}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
